// File: rtl/nic_pkg.sv
// Shared constants, types and helpers for the NIC controller slice.
package nic_pkg;

   localparam int DATA_W = 64;
   localparam int CNT_W  = 16;

   // Processor-visible locations.
   localparam logic [1:0] NIC_OUT_BUF  = 2'b00;
   localparam logic [1:0] NIC_OUT_STAT = 2'b01;
   localparam logic [1:0] NIC_IN_BUF   = 2'b10;
   localparam logic [1:0] NIC_IN_STAT  = 2'b11;

   // Status word layout, big-endian numbering (bit 0 is the MSB).
   localparam int STAT_CNT_FIRST = 32;
   localparam int STAT_CNT_LAST  = 47;
   localparam int STAT_FULL_BIT  = 63;

   typedef enum logic {
      CH_EMPTY = 1'b0,
      CH_FULL  = 1'b1
   } ch_state_e;

   // Pack a channel counter and full flag into a status word.
   function automatic logic [0:DATA_W-1] make_status(input logic [CNT_W-1:0] cnt,
                                                     input logic             full);
      logic [0:DATA_W-1] w_word;
      w_word = '0;
      w_word[STAT_CNT_FIRST:STAT_CNT_LAST] = cnt;
      w_word[STAT_FULL_BIT] = full;
      return w_word;
   endfunction

endpackage

// File: rtl/nic_if.sv
// Processor NIC port plus router port, bundled as one interface.
interface nic_if;
   import nic_pkg::*;

   // Processor side
   logic              nicEn;
   logic              nicWrEn;
   logic [0:1]        addr_nic;
   logic [0:DATA_W-1] d_in;
   logic [0:DATA_W-1] d_out;

   // Router side
   logic              net_so;
   logic              net_ro;
   logic [0:DATA_W-1] net_do;
   logic              net_si;
   logic              net_ri;
   logic [0:DATA_W-1] net_di;

   // The controller end of the bundle.
   modport slave (
      input  nicEn, nicWrEn, addr_nic, d_in, net_ro, net_si, net_di,
      output d_out, net_so, net_do, net_ri
   );

   // The processor/router end of the bundle.
   modport master (
      output nicEn, nicWrEn, addr_nic, d_in, net_ro, net_si, net_di,
      input  d_out, net_so, net_do, net_ri
   );

endinterface

// File: rtl/nic_channel_buffer.sv
// One-entry channel buffer: 64-bit register, EMPTY/FULL FSM and a 16-bit
// wrapping packet counter. COUNT_ON_FILL picks which event is counted
// (fill for the input channel, drain for the output channel).
module nic_channel_buffer
   import nic_pkg::*;
#(
   parameter bit COUNT_ON_FILL = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fill,
   input  logic [0:DATA_W-1] fill_data,
   input  logic              drain,
   output logic [0:DATA_W-1] data,
   output logic              full,
   output logic [CNT_W-1:0]  count
);

   ch_state_e         r_state;
   ch_state_e         w_state_next;
   logic [0:DATA_W-1] r_data;
   logic [CNT_W-1:0]  r_count;
   logic              w_do_fill;
   logic              w_do_drain;
   logic              w_count_en;

   // Fill is only honoured when empty and drain only when full, so the two
   // can never act on the same edge.
   assign w_do_fill  = fill  & (r_state == CH_EMPTY);
   assign w_do_drain = drain & (r_state == CH_FULL);
   assign w_count_en = COUNT_ON_FILL ? w_do_fill : w_do_drain;

   // Next-state logic for the EMPTY/FULL FSM.
   always_comb begin
      // NOTE: default first so every path assigns w_state_next and no latch is inferred.
      w_state_next = r_state;
      case (r_state)
         CH_EMPTY: if (w_do_fill)  w_state_next = CH_FULL;
         CH_FULL:  if (w_do_drain) w_state_next = CH_EMPTY;
         default:                  w_state_next = CH_EMPTY;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so all flops see pre-edge values.
      if (reset) r_state <= CH_EMPTY;
      else       r_state <= w_state_next;
   end

   // Data register and packet counter.
   always_ff @(posedge clk) begin
      // NOTE: the 64-bit buffer is reset too, because its value is visible on net_do right after reset.
      if (reset) begin
         r_data  <= '0;
         r_count <= '0;
      end else begin
         if (w_do_fill)  r_data  <= fill_data;
         if (w_count_en) r_count <= r_count + 1'b1;
      end
   end

   assign data  = r_data;
   assign full  = (r_state == CH_FULL);
   assign count = r_count;

endmodule

// File: rtl/nic_controller.sv
// NIC between the processor's NIC port and a mesh router port: address
// decode, handshake gating and the registered processor read path.
module nic_controller
   import nic_pkg::*;
(
   input  logic  clk,
   input  logic  reset,
   nic_if.slave  bus
);

   logic              w_rd;
   logic              w_wr;
   logic              w_out_fill;
   logic              w_in_drain;
   logic              w_out_full;
   logic              w_in_full;
   logic [0:DATA_W-1] w_out_data;
   logic [0:DATA_W-1] w_in_data;
   logic [CNT_W-1:0]  w_tx_cnt;
   logic [CNT_W-1:0]  w_rx_cnt;
   logic [0:DATA_W-1] w_rd_data;
   logic [0:DATA_W-1] r_d_out;

   assign w_rd       = bus.nicEn & ~bus.nicWrEn;
   assign w_wr       = bus.nicEn &  bus.nicWrEn;
   assign w_out_fill = w_wr & (bus.addr_nic == NIC_OUT_BUF);
   assign w_in_drain = w_rd & (bus.addr_nic == NIC_IN_BUF);

   // Output channel: filled by the processor, drained by the router.
   // net_so is the full flag, so net_ro alone acts as the drain request.
   nic_channel_buffer #(.COUNT_ON_FILL(1'b0)) u_out_chan (
      .clk       (clk),
      .reset     (reset),
      .fill      (w_out_fill),
      .fill_data (bus.d_in),
      .drain     (bus.net_ro),
      .data      (w_out_data),
      .full      (w_out_full),
      .count     (w_tx_cnt)
   );

   // Input channel: filled by the router, drained by a processor read.
   // net_ri is !full, so net_si alone acts as the fill request.
   nic_channel_buffer #(.COUNT_ON_FILL(1'b1)) u_in_chan (
      .clk       (clk),
      .reset     (reset),
      .fill      (bus.net_si),
      .fill_data (bus.net_di),
      .drain     (w_in_drain),
      .data      (w_in_data),
      .full      (w_in_full),
      .count     (w_rx_cnt)
   );

   // Read-data select from pre-edge buffer and status values.
   always_comb begin
      w_rd_data = '0;
      case (bus.addr_nic)
         NIC_OUT_BUF:  w_rd_data = w_out_data;
         NIC_OUT_STAT: w_rd_data = make_status(w_tx_cnt, w_out_full);
         NIC_IN_BUF:   w_rd_data = w_in_data;
         NIC_IN_STAT:  w_rd_data = make_status(w_rx_cnt, w_in_full);
         default:      w_rd_data = '0;
      endcase
   end

   // Registered processor read data; holds on writes and when idle.
   always_ff @(posedge clk) begin
      if (reset)     r_d_out <= '0;
      else if (w_rd) r_d_out <= w_rd_data;
   end

   assign bus.d_out  = r_d_out;
   assign bus.net_so = w_out_full;
   assign bus.net_do = w_out_data;
   assign bus.net_ri = ~w_in_full;

endmodule

// File: tb/tb_nic_controller.sv
// Directed self-checking bench for nic_controller.
module tb_nic_controller;
   import nic_pkg::*;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   nic_if bus ();

   nic_controller dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one edge; inputs change and outputs are sampled 1 unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [1:0] a);
      bus.nicEn    = 1'b1;
      bus.nicWrEn  = 1'b0;
      bus.addr_nic = a;
      tick();
      bus.nicEn    = 1'b0;
   endtask

   task automatic wr(input logic [1:0] a, input logic [63:0] d);
      bus.nicEn    = 1'b1;
      bus.nicWrEn  = 1'b1;
      bus.addr_nic = a;
      bus.d_in     = d;
      tick();
      bus.nicEn    = 1'b0;
      bus.nicWrEn  = 1'b0;
   endtask

   initial begin
      checks       = 0;
      errors       = 0;
      reset        = 1'b1;
      bus.nicEn    = 1'b0;
      bus.nicWrEn  = 1'b0;
      bus.addr_nic = 2'b00;
      bus.d_in     = '0;
      bus.net_ro   = 1'b0;
      bus.net_si   = 1'b0;
      bus.net_di   = '0;
      tick();
      tick();
      reset = 1'b0;

      // Reset state
      check("rst_net_so", 64'(bus.net_so), 64'd0);
      check("rst_net_ri", 64'(bus.net_ri), 64'd1);
      check("rst_net_do", bus.net_do, 64'd0);
      check("rst_d_out",  bus.d_out,  64'd0);
      rd(NIC_OUT_STAT);
      check("rst_stat_out", bus.d_out, 64'd0);
      rd(NIC_IN_STAT);
      check("rst_stat_in", bus.d_out, 64'd0);

      // Output channel: write, hold while router not ready
      wr(NIC_OUT_BUF, 64'hDEADBEEF_00000001);
      check("wr_net_so", 64'(bus.net_so), 64'd1);
      check("wr_net_do", bus.net_do, 64'hDEADBEEF_00000001);
      tick();
      tick();
      check("hold_net_so", 64'(bus.net_so), 64'd1);
      wr(NIC_OUT_BUF, 64'h5);
      check("drop_write", bus.net_do, 64'hDEADBEEF_00000001);
      rd(NIC_OUT_STAT);
      check("stat_out_full", bus.d_out, 64'h00000000_00000001);

      // Router takes the packet
      bus.net_ro = 1'b1;
      tick();
      bus.net_ro = 1'b0;
      check("tx_net_so", 64'(bus.net_so), 64'd0);
      check("tx_net_do_kept", bus.net_do, 64'hDEADBEEF_00000001);
      rd(NIC_OUT_STAT);
      check("stat_out_tx1", bus.d_out, 64'h00000000_00010000);
      tick();
      check("d_out_hold", bus.d_out, 64'h00000000_00010000);

      // Write in the same cycle the buffer drains is still dropped
      wr(NIC_OUT_BUF, 64'h77);
      check("refill_net_so", 64'(bus.net_so), 64'd1);
      bus.nicEn    = 1'b1;
      bus.nicWrEn  = 1'b1;
      bus.addr_nic = NIC_OUT_BUF;
      bus.d_in     = 64'h99;
      bus.net_ro   = 1'b1;
      tick();
      bus.nicEn    = 1'b0;
      bus.nicWrEn  = 1'b0;
      bus.net_ro   = 1'b0;
      check("late_wr_net_so", 64'(bus.net_so), 64'd0);
      check("late_wr_net_do", bus.net_do, 64'h77);
      rd(NIC_OUT_STAT);
      check("stat_out_tx2", bus.d_out, 64'h00000000_00020000);

      // Input channel capture
      bus.net_si = 1'b1;
      bus.net_di = 64'hA5A5A5A5_A5A5A5A5;
      tick();
      check("rx_net_ri", 64'(bus.net_ri), 64'd0);
      // Second packet offered while full, together with a status read
      bus.net_di   = 64'h1234;
      bus.nicEn    = 1'b1;
      bus.nicWrEn  = 1'b0;
      bus.addr_nic = NIC_IN_STAT;
      tick();
      bus.nicEn  = 1'b0;
      bus.net_si = 1'b0;
      check("stat_in_full", bus.d_out, 64'h00000000_00010001);
      rd(NIC_IN_BUF);
      check("rd_in_buf", bus.d_out, 64'hA5A5A5A5_A5A5A5A5);
      check("rd_net_ri", 64'(bus.net_ri), 64'd1);
      rd(NIC_IN_BUF);
      check("rd_in_stale", bus.d_out, 64'hA5A5A5A5_A5A5A5A5);
      rd(NIC_IN_STAT);
      check("stat_in_cnt1", bus.d_out, 64'h00000000_00010000);

      // Counter wrap: 65534 more packets bring rx_cnt to 0xFFFF
      for (int i = 0; i < 65534; i++) begin
         bus.net_si = 1'b1;
         bus.net_di = 64'(i);
         tick();
         bus.net_si = 1'b0;
         rd(NIC_IN_BUF);
      end
      check("last_pkt_data", bus.d_out, 64'd65533);
      rd(NIC_IN_STAT);
      check("stat_in_ffff", bus.d_out, 64'h00000000_FFFF0000);
      bus.net_si = 1'b1;
      bus.net_di = 64'hFEEDFACE_0BADF00D;
      tick();
      bus.net_si = 1'b0;
      rd(NIC_IN_STAT);
      check("stat_in_wrap", bus.d_out, 64'h00000000_00000001);
      rd(NIC_IN_BUF);
      check("rd_after_wrap", bus.d_out, 64'hFEEDFACE_0BADF00D);

      // Reset during a pending transfer
      wr(NIC_OUT_BUF, 64'hCAFE);
      check("pre_rst_net_so", 64'(bus.net_so), 64'd1);
      bus.net_ro = 1'b1;
      reset      = 1'b1;
      tick();
      reset      = 1'b0;
      bus.net_ro = 1'b0;
      check("mid_rst_net_so", 64'(bus.net_so), 64'd0);
      check("mid_rst_net_do", bus.net_do, 64'd0);
      check("mid_rst_net_ri", 64'(bus.net_ri), 64'd1);
      check("mid_rst_d_out",  bus.d_out,  64'd0);
      rd(NIC_OUT_STAT);
      check("mid_rst_tx_cnt", bus.d_out, 64'd0);
      rd(NIC_IN_STAT);
      check("mid_rst_rx_cnt", bus.d_out, 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/nic_controller.md
# nic_controller

Network interface controller between the four-stage processor's NIC port and one mesh router port. It holds one 64-bit output-channel buffer and one 64-bit input-channel buffer, each with its own full/empty state machine. It exposes four processor-addressable locations: two buffers and two status words. It sequences packet injection into the router and ejection from it over valid/ready handshakes.

## Interface
- No parameters; widths are fixed at 64-bit data and a 2-bit address.
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- nicEn  in  1  processor NIC access enable.
- nicWrEn  in  1  write enable; meaningful only when nicEn=1.
- addr_nic  in  [0:1]  location select:
  - 00 output buffer
  - 01 output status
  - 10 input buffer
  - 11 input status
- d_in  in  [0:63]  write data from the processor.
- d_out  out  [0:63]  registered read data to the processor.
- net_so  out  1  send-out valid to the router.
- net_ro  in  1  router ready to accept.
- net_do  out  [0:63]  packet to the router; always equals the output buffer.
- net_si  in  1  packet valid from the router.
- net_ri  out  1  ready to accept a packet from the router.
- net_di  in  [0:63]  packet from the router.

## Operation
- Each channel has a 2-state FSM, EMPTY and FULL, held in a full flag.
- Output channel:
  - Processor write to 00 when EMPTY: buffer <= d_in, go to FULL.
  - Processor write to 00 when FULL: dropped; buffer and FSM are unchanged.
  - net_so = out_full.
  - A transfer occurs on the edge where net_so & net_ro = 1. The FSM goes to EMPTY and tx_cnt increments.
- Input channel:
  - net_ri = !in_full.
  - On the edge where net_si & net_ri = 1: buffer <= net_di, go to FULL, rx_cnt increments.
  - Processor read of 10: d_out <= buffer. If FULL, the FSM goes to EMPTY on the same edge.
  - Processor read of 10 when EMPTY: returns stale buffer contents; no state change.
- Status words read at 01 and 11:
  - bits [0:31] are 0.
  - bits [32:47] are tx_cnt (01) or rx_cnt (11).
  - bits [48:62] are 0.
  - bit 63 is out_full (01) or in_full (11).
- Counters are 16-bit and wrap from 0xFFFF to 0x0000.
- Writes to 01, 10 or 11 are ignored.
- When nicEn=0, d_out holds its previous value.
- All decisions use flag values sampled at the start of the cycle:
  - A write to 00 in the same cycle a transmit empties the buffer is still dropped.
  - A status read returns the pre-edge value.

## Timing
- Reset values:
  - d_out=0, net_so=0, net_ri=1, net_do=0.
  - Both buffers are 0, both FSMs are EMPTY, both counters are 0.
- Reset in the middle of a handshake discards any buffered packet. No transfer is counted on the reset edge.
- Read latency is 1 cycle: d_out is valid the cycle after nicEn=1, nicWrEn=0.
- Write to transmit:
  - A write at edge N makes net_so=1 in cycle N+1.
  - The earliest transfer is at edge N+1 if net_ro=1.
- Receive to read:
  - A capture at edge N makes the status bit 63 read 1 in cycle N+1.
  - The buffer is readable from cycle N+1.
- Back-to-back throughput:
  - Output: one packet per 2 cycles (write, then transmit).
  - Input: one packet per 2 cycles (capture, then read).
- Every net_* output is a function of registered state only; there is no combinational path from any input.

## Structure
- nic_pkg holds:
  - the address constants NIC_OUT_BUF=2'b00, NIC_OUT_STAT=2'b01, NIC_IN_BUF=2'b10, NIC_IN_STAT=2'b11;
  - the channel state enum {CH_EMPTY, CH_FULL};
  - the status bit positions and the counter width (16).
- Sub-module nic_channel_buffer contains the 64-bit register, the EMPTY/FULL FSM and the 16-bit wrap counter.
  - Ports: fill, fill_data, drain, data, full, count.
  - It is instantiated twice, once for output and once for input.
- The top level contains the address decode, the handshake gating and the d_out register.

## Test plan
- Reset, then read 01 and 11: d_out=0 each time. Check net_ri=1 and net_so=0.
- Write 0xDEADBEEF_00000001 to 00 with net_ro=0 for 3 cycles:
  - net_so=1 and net_do holds the value.
  - A second write of 0x5 is dropped.
  - Raise net_ro: one transfer, net_so=0 next cycle, status 01 reads 0x00000000_00010000.
- Drive net_si=1 with net_di=0xA5A5A5A5_A5A5A5A5:
  - Captured on the next edge, net_ri drops to 0.
  - Status 11 reads bit63=1 with count 1.
  - A later net_si with 0x1234 is not accepted while FULL.
- Read 10: the next cycle gives d_out=0xA5A5A5A5_A5A5A5A5 and net_ri=1. A second read of 10 returns the same value and the count stays 1.
- Send 65536 packets through the input channel: rx_cnt wraps to 0 and status 11 bits [32:47] read 0x0000.
- Fill the output channel, then assert reset while net_ro=1 in the same cycle: afterwards net_so=0, tx_cnt=0 and no transfer is counted.
